// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO result registers.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : asynchronous active-high reset, clears all state
//   start  : command strobe, accepted only while busy is low
//   mdop   : 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo,
//            000/111 no operation
//   A, B   : operands, captured at the accepting edge
//   busy   : high while a mult/div is in flight (registered)
//   done   : one-cycle pulse in the cycle after HI/LO take a mult/div result
//   HI, LO : result register contents
//
// The arithmetic result is computed combinationally at the accepting edge
// and parked in holding registers; the state machine only models latency
// and commits the parked result when the countdown expires.
// ---------------------------------------------------------------------------
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        wr_q, wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Arithmetic datapath, evaluated from the live operands; only sampled
    // into the holding registers at the accepting edge.
    logic signed [63:0] mul_s;
    logic        [63:0] mul_u;
    logic        [31:0] b_safe;
    logic        [31:0] a_mag, b_mag, b_mag_safe;
    logic        [31:0] uquo, urem, squo_mag, srem_mag;
    logic        [31:0] squo, srem;

    always_comb begin
        mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        mul_u = {32'd0, A} * {32'd0, B};

        // A zero divisor is replaced by 1 so the divider never produces X;
        // the result is discarded anyway because wr_d is cleared.
        b_safe = (B == 32'd0) ? 32'd1 : B;
        uquo   = A / b_safe;
        urem   = A % b_safe;

        // Signed divide via magnitudes; truncation toward zero and a
        // remainder that follows the dividend's sign fall out naturally.
        // The 0x80000000 / -1 case yields magnitude 0x80000000, which wraps
        // back to 0x80000000 with remainder 0.
        a_mag      = A[31] ? (~A + 32'd1) : A;
        b_mag      = B[31] ? (~B + 32'd1) : B;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        squo_mag   = a_mag / b_mag_safe;
        srem_mag   = a_mag % b_mag_safe;
        squo       = (A[31] ^ B[31]) ? (~squo_mag + 32'd1) : squo_mag;
        srem       = A[31] ? (~srem_mag + 32'd1) : srem_mag;
    end

    // Command acceptance, latency countdown and result commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdop)
                        OP_MULT: begin
                            state_d  = RUN;
                            cnt_d    = MUL_CYCLES;
                            res_hi_d = mul_s[63:32];
                            res_lo_d = mul_s[31:0];
                            wr_d     = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = RUN;
                            cnt_d    = MUL_CYCLES;
                            res_hi_d = mul_u[63:32];
                            res_lo_d = mul_u[31:0];
                            wr_d     = 1'b1;
                        end
                        OP_DIV: begin
                            state_d  = RUN;
                            cnt_d    = DIV_CYCLES;
                            res_hi_d = srem;
                            res_lo_d = squo;
                            wr_d     = (B != 32'd0);
                        end
                        OP_DIVU: begin
                            state_d  = RUN;
                            cnt_d    = DIV_CYCLES;
                            res_hi_d = urem;
                            res_lo_d = uquo;
                            wr_d     = (B != 32'd0);
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            wr_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for the mdu block.
// Inputs are driven and outputs sampled on the falling clock edge, half a
// cycle away from the edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors;
    int miscompares;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one command for exactly one rising edge; must be called at a
    // falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'b000;
    endtask

    // Issues a mult/div, scrambles the operands after acceptance, optionally
    // fires an extra (to-be-ignored) mult start at busy cycle injectAt, then
    // waits out the busy period and checks latency, done and HI/LO.
    // Returns at the falling edge where done should be high.
    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int expCycles, input int injectAt,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int n;
        logic doneWhileBusy;
        applyStimulus(op, a, b);
        A = 32'hDEADBEEF;
        B = 32'h00000003;
        n = 0;
        doneWhileBusy = 1'b0;
        while (busy && n < 40) begin
            n++;
            if (done) doneWhileBusy = 1'b1;
            start = 1'b0;
            mdop  = 3'b000;
            if (n == injectAt) begin
                start = 1'b1;
                mdop  = 3'b001;
                A     = 32'h00000005;
                B     = 32'h00000005;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mdop  = 3'b000;
        checkOutput({tag, " busy cycles"}, 32'(n), 32'(expCycles));
        checkOutput({tag, " done overlap"}, {31'd0, doneWhileBusy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " HI"}, HI, expHi);
        checkOutput({tag, " LO"}, LO, expLo);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'b000;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // -2 * 3 = -6 as 64-bit signed.
        runOp("mult", 3'b001, 32'hFFFFFFFE, 32'd3, 5, 0,
              32'hFFFFFFFF, 32'hFFFFFFFA);
        @(negedge clk);
        checkOutput("mult done pulse width", {31'd0, done}, 32'd0);

        // (2^32-1)^2 = 0xFFFFFFFE_00000001.
        runOp("multu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0,
              32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);

        // -7 / 2 -> quotient -3, remainder -1.
        runOp("div", 3'b011, 32'hFFFFFFF9, 32'd2, 10, 0,
              32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clk);

        // Divide by zero leaves the previous div result in place.
        runOp("divu by zero", 3'b100, 32'd7, 32'd0, 10, 0,
              32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clk);

        // No-op codes must not start anything.
        applyStimulus(3'b000, 32'h11111111, 32'h22222222);
        checkOutput("nop000 busy", {31'd0, busy}, 32'd0);
        applyStimulus(3'b111, 32'h11111111, 32'h22222222);
        checkOutput("nop111 busy", {31'd0, busy}, 32'd0);
        checkOutput("nop HI", HI, 32'hFFFFFFFF);

        // mthi then mtlo on consecutive cycles.
        applyStimulus(3'b101, 32'h12345678, 32'd0);
        checkOutput("mthi busy", {31'd0, busy}, 32'd0);
        applyStimulus(3'b110, 32'h9ABCDEF0, 32'd0);
        checkOutput("mtlo busy", {31'd0, busy}, 32'd0);
        checkOutput("mtlo done", {31'd0, done}, 32'd0);
        checkOutput("mthi HI", HI, 32'h12345678);
        checkOutput("mtlo LO", LO, 32'h9ABCDEF0);

        // divu 100/7 with a mult start injected at busy cycle 3 (ignored).
        runOp("divu inject", 3'b100, 32'd100, 32'd7, 10, 3,
              32'd2, 32'd14);
        @(negedge clk);
        checkOutput("after inject busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a divide aborts it immediately.
        applyStimulus(3'b011, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        checkOutput("mid-div busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", {31'd0, busy}, 32'd0);
        checkOutput("async reset HI", HI, 32'd0);
        checkOutput("async reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("post-abort HI", HI, 32'd0);
        checkOutput("post-abort LO", LO, 32'd0);
        checkOutput("post-abort done", {31'd0, done}, 32'd0);

        // Signed overflow case, then a multu issued in the done cycle.
        runOp("div overflow", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 0,
              32'h00000000, 32'h80000000);
        runOp("back-to-back multu", 3'b010, 32'd6, 32'd7, 5, 0,
              32'd0, 32'd42);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
